// File: rtl/io_mmio_pkg.sv
// io_mmio_pkg -- shared definitions for the io_mmio I/O window.
//   * Register offsets inside the 64-byte window (addr[5:0]).
//   * TX handshake FSM state encoding.
//   * Counter width used by io_mmio_counter.
package io_mmio_pkg;

  localparam int CNT_W = 32;

  localparam logic [5:0] OFF_CTRL   = 6'h00;  // RO: {rx valid, tx ready}
  localparam logic [5:0] OFF_RXDATA = 6'h04;  // RO: received byte
  localparam logic [5:0] OFF_TXDATA = 6'h08;  // WO: transmit byte
  localparam logic [5:0] OFF_CYCLE  = 6'h10;  // RO: cycle counter
  localparam logic [5:0] OFF_INSTR  = 6'h14;  // RO: retired-instruction counter
  localparam logic [5:0] OFF_CLR    = 6'h18;  // WO: any store clears counters
  localparam logic [5:0] OFF_BRANCH = 6'h1C;  // RO: branch counter (optional)
  localparam logic [5:0] OFF_BRCORR = 6'h20;  // RO: correct-prediction counter (optional)

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/io_mmio_counter.sv
// io_mmio_counter -- 32-bit wrapping event counter.
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset (clears count)
//   inc   : count one event this cycle
//   clr   : clear request; wins over inc
//   count : current value
module io_mmio_counter
  import io_mmio_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/io_mmio.sv
// io_mmio -- memory-mapped I/O window: UART TX/RX ready/valid bridge plus
// cycle and retired-instruction performance counters.
// Optional feature macro: IO_MMIO_BRANCH_CNT_EN adds branch_valid /
// branch_taken_correct inputs and two branch counters at 0x1C / 0x20.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   addr, wdata, we, re      : CPU load/store port (one-cycle strobes)
//   rdata                    : load data, registered, 0 when not following re
//   instr_retired            : one pulse per retired instruction
//   tx_data_in[_valid/_ready]: byte link to the UART transmitter
//   rx_data_out[_valid/_ready]: byte link from the UART receiver
module io_mmio
  import io_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  input  logic        instr_retired,
  output logic [7:0]  tx_data_in,
  output logic        tx_data_in_valid,
  input  logic        tx_data_in_ready,
  input  logic [7:0]  rx_data_out,
  input  logic        rx_data_out_valid,
  output logic        rx_data_out_ready
`ifdef IO_MMIO_BRANCH_CNT_EN
  ,
  input  logic        branch_valid,
  input  logic        branch_taken_correct
`endif
);

  logic        hit;
  logic [5:0]  off;
  logic        rd;
  logic        wr;
  logic        clr_cnt;
  logic        tx_store;
  logic        tx_free;
  logic [31:0] rd_mux;
  logic [31:0] cyc_cnt;
  logic [31:0] ins_cnt;
  tx_state_t   state;
  tx_state_t   state_next;
  logic        tx_load;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign hit      = (addr[31:6] == BASE_ADDR[31:6]);
  assign off      = addr[5:0];
  assign rd       = re && hit;
  assign wr       = we && hit;
  assign clr_cnt  = wr && (off == OFF_CLR);
  assign tx_store = wr && (off == OFF_TXDATA);
  assign tx_free  = tx_data_in_ready && (state == TX_IDLE);

  // The receiver sees ready in the same cycle as the load, so the byte it
  // presents is the one captured into rdata.
  assign rx_data_out_ready = !rst && rd && (off == OFF_RXDATA) && rx_data_out_valid;

  io_mmio_counter u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .clr   (clr_cnt),
    .count (cyc_cnt)
  );

  io_mmio_counter u_ins_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_retired),
    .clr   (clr_cnt),
    .count (ins_cnt)
  );

`ifdef IO_MMIO_BRANCH_CNT_EN
  logic [31:0] br_cnt;
  logic [31:0] brc_cnt;

  io_mmio_counter u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_valid),
    .clr   (clr_cnt),
    .count (br_cnt)
  );

  io_mmio_counter u_brc_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_valid && branch_taken_correct),
    .clr   (clr_cnt),
    .count (brc_cnt)
  );
`endif

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CTRL:   rd_mux = {30'b0, rx_data_out_valid, tx_free};
      OFF_RXDATA: rd_mux = {24'b0, rx_data_out};
      OFF_CYCLE:  rd_mux = cyc_cnt;
      OFF_INSTR:  rd_mux = ins_cnt;
`ifdef IO_MMIO_BRANCH_CNT_EN
      OFF_BRANCH: rd_mux = br_cnt;
      OFF_BRCORR: rd_mux = brc_cnt;
`endif
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd) begin
      rdata <= rd_mux;
    end else begin
      rdata <= '0;
    end
  end

  // TX FSM: a byte is accepted only in IDLE; stores arriving while a byte
  // is pending are dropped so the pending byte stays stable.
  always_comb begin
    state_next       = state;
    tx_load          = 1'b0;
    tx_data_in_valid = 1'b0;
    case (state)
      TX_IDLE: begin
        if (tx_store) begin
          tx_load    = 1'b1;
          state_next = TX_PEND;
        end
      end
      TX_PEND: begin
        tx_data_in_valid = 1'b1;
        if (tx_data_in_ready) begin
          state_next = TX_IDLE;
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= TX_IDLE;
      tx_data_in <= '0;
    end else begin
      state <= state_next;
      if (tx_load) begin
        tx_data_in <= wdata[7:0];
      end
    end
  end

endmodule

// File: tb/tb_io_mmio.sv
// tb_io_mmio -- self-checking bench for io_mmio (default build).
module tb_io_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        instr_retired;
  logic [7:0]  tx_data_in;
  logic        tx_data_in_valid;
  logic        tx_data_in_ready;
  logic [7:0]  rx_data_out;
  logic        rx_data_out_valid;
  logic        rx_data_out_ready;

  always #5 clk = ~clk;

  io_mmio #(.BASE_ADDR(32'h8000_0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .addr              (addr),
    .wdata             (wdata),
    .we                (we),
    .re                (re),
    .rdata             (rdata),
    .instr_retired     (instr_retired),
    .tx_data_in        (tx_data_in),
    .tx_data_in_valid  (tx_data_in_valid),
    .tx_data_in_ready  (tx_data_in_ready),
    .rx_data_out       (rx_data_out),
    .rx_data_out_valid (rx_data_out_valid),
    .rx_data_out_ready (rx_data_out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  rx;
    logic        rx_v;
    logic        tx_r;
    logic [31:0] exp;
    logic        exp_rdy;
    string       name;
  } vec_t;
  vec_t vecs[$];

  // Reference counter values (what the DUT registers hold before the next edge).
  logic [31:0] cyc_m = '0;
  logic [31:0] ins_m = '0;

  // Handshake monitors.
  int         hs_cnt  = 0;
  logic [7:0] hs_byte = '0;
  int         rdy_cnt = 0;

  always @(posedge clk) begin
    if (tx_data_in_valid && tx_data_in_ready) begin
      hs_cnt  <= hs_cnt + 1;
      hs_byte <= tx_data_in;
    end
    if (rx_data_out_ready) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: update the reference counters from the inputs presented at
  // this edge, then compare rdata against the scoreboard (or 0 when idle).
  task automatic step();
    logic clr_hit;
    sb_t  e;
    clr_hit = we && (addr == 32'h8000_0018);
    @(posedge clk);
    if (rst || clr_hit) begin
      cyc_m = '0;
      ins_m = '0;
    end else begin
      cyc_m = cyc_m + 32'd1;
      if (instr_retired) ins_m = ins_m + 32'd1;
    end
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, rdata, e.exp);
    end else begin
      check("rdata_idle", rdata, 32'h0);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a;
    re   = 1'b1;
    sb.push_back('{exp, name});
    step();
    re   = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  initial begin
    logic [31:0] first;
    int          base;

    vecs.push_back('{32'h8000_0000, 8'h00, 1'b0, 1'b1, 32'h1,  1'b0, "ctrl_txrdy"});
    vecs.push_back('{32'h8000_0000, 8'h00, 1'b1, 1'b0, 32'h2,  1'b0, "ctrl_rxvld"});
    vecs.push_back('{32'h8000_0000, 8'h00, 1'b1, 1'b1, 32'h3,  1'b0, "ctrl_both"});
    vecs.push_back('{32'h8000_0004, 8'h5A, 1'b1, 1'b0, 32'h5A, 1'b1, "rx_valid"});
    vecs.push_back('{32'h8000_0004, 8'hA5, 1'b0, 1'b0, 32'hA5, 1'b0, "rx_novalid"});
    vecs.push_back('{32'h8000_000C, 8'h00, 1'b1, 1'b1, 32'h0,  1'b0, "unmapped_0c"});
    vecs.push_back('{32'h9000_0010, 8'h00, 1'b0, 1'b1, 32'h0,  1'b0, "outside_9000"});
    vecs.push_back('{32'h9000_0004, 8'h33, 1'b1, 1'b0, 32'h0,  1'b0, "outside_rx"});
    vecs.push_back('{32'h8000_0044, 8'h00, 1'b0, 1'b0, 32'h0,  1'b0, "outside_44"});
    vecs.push_back('{32'h8000_0008, 8'h00, 1'b0, 1'b0, 32'h0,  1'b0, "read_txdata"});
    vecs.push_back('{32'h8000_0018, 8'h00, 1'b0, 1'b0, 32'h0,  1'b0, "read_clr"});
    vecs.push_back('{32'h8000_001C, 8'h00, 1'b0, 1'b0, 32'h0,  1'b0, "read_br"});
    vecs.push_back('{32'h8000_0020, 8'h00, 1'b0, 1'b0, 32'h0,  1'b0, "read_brc"});

    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    instr_retired = 1'b0; tx_data_in_ready = 1'b0;
    rx_data_out = 8'h5A; rx_data_out_valid = 1'b1;

    // Reset: no ready pulse even with a load to 0x04 in flight.
    step();
    addr = 32'h8000_0004; re = 1'b1;
    #1;
    check("rst_rx_ready", {31'b0, rx_data_out_ready}, 32'h0);
    sb.push_back('{32'h0, "rst_rdata"});
    step();
    re = 1'b0;
    check("rst_tx_valid", {31'b0, tx_data_in_valid}, 32'h0);
    check("rst_tx_data", {24'b0, tx_data_in}, 32'h0);
    rst = 1'b0;
    rx_data_out_valid = 1'b0;

    // Table of single-load vectors with TX idle.
    foreach (vecs[i]) begin
      rx_data_out       = vecs[i].rx;
      rx_data_out_valid = vecs[i].rx_v;
      tx_data_in_ready  = vecs[i].tx_r;
      addr              = vecs[i].addr;
      re                = 1'b1;
      #1;
      check({vecs[i].name, "_rdy"}, {31'b0, rx_data_out_ready}, {31'b0, vecs[i].exp_rdy});
      sb.push_back('{vecs[i].exp, vecs[i].name});
      step();
      re = 1'b0;
    end
    rx_data_out_valid = 1'b0;
    tx_data_in_ready  = 1'b0;

    // Cycle counter after 100 idle cycles, then monotonic.
    repeat (100) step();
    load(32'h8000_0010, cyc_m, "cycle_cnt_100");
    first = rdata;
    load(32'h8000_0010, cyc_m, "cycle_cnt_again");
    check("cycle_monotonic", {31'b0, (rdata > first)}, 32'h1);

    // Instruction counter, clear coinciding with an increment.
    instr_retired = 1'b1;
    repeat (7) step();
    instr_retired = 1'b0;
    load(32'h8000_0014, 32'd7, "instr_7");
    instr_retired = 1'b1;
    store(32'h8000_0018, 32'hDEAD_BEEF);
    instr_retired = 1'b0;
    load(32'h8000_0014, 32'h0, "instr_after_clr");
    load(32'h8000_0010, cyc_m, "cycle_after_clr");

    // Stores to read-only / outside addresses have no effect.
    store(32'h8000_0010, 32'h1234_5678);
    store(32'h9000_0018, 32'h0);
    store(32'h9000_0008, 32'h99);
    check("outside_tx_store", {31'b0, tx_data_in_valid}, 32'h0);
    load(32'h8000_0010, cyc_m, "cycle_no_side_effect");

    // Simultaneous load and store on the same cycle.
    we = 1'b1; wdata = 32'h77;
    load(32'h8000_0008, 32'h0, "rw_same_cycle");
    we = 1'b0;
    check("rw_tx_valid", {31'b0, tx_data_in_valid}, 32'h1);
    check("rw_tx_data", {24'b0, tx_data_in}, 32'h77);
    tx_data_in_ready = 1'b1;
    step();
    tx_data_in_ready = 1'b0;

    // TX: second store while pending is dropped; one handshake with 0x41.
    base = hs_cnt;
    store(32'h8000_0008, 32'h41);
    check("tx_pend_valid", {31'b0, tx_data_in_valid}, 32'h1);
    check("tx_pend_data", {24'b0, tx_data_in}, 32'h41);
    store(32'h8000_0008, 32'h42);
    check("tx_drop_data", {24'b0, tx_data_in}, 32'h41);
    tx_data_in_ready = 1'b1;
    load(32'h8000_0000, 32'h0, "ctrl_while_pend");
    step();
    step();
    check("tx_hs_count", hs_cnt - base, 32'd1);
    check("tx_hs_byte", {24'b0, hs_byte}, 32'h41);
    check("tx_idle_valid", {31'b0, tx_data_in_valid}, 32'h0);
    load(32'h8000_0000, 32'h1, "ctrl_after_hs");
    tx_data_in_ready = 1'b0;

    // RX: ready pulse is exactly one cycle, and absent when not valid.
    rx_data_out = 8'h5A; rx_data_out_valid = 1'b1;
    base = rdy_cnt;
    load(32'h8000_0004, 32'h5A, "rx_load_valid");
    step();
    check("rx_rdy_pulses", rdy_cnt - base, 32'd1);
    rx_data_out_valid = 1'b0;
    base = rdy_cnt;
    load(32'h8000_0004, 32'h5A, "rx_load_novalid");
    step();
    check("rx_rdy_none", rdy_cnt - base, 32'd0);

    // Reset while pending abandons the byte and clears counters.
    store(32'h8000_0008, 32'h55);
    check("pend2_valid", {31'b0, tx_data_in_valid}, 32'h1);
    instr_retired = 1'b1;
    step();
    step();
    instr_retired = 1'b0;
    base = hs_cnt;
    rst = 1'b1;
    step();
    check("rstpend_valid", {31'b0, tx_data_in_valid}, 32'h0);
    check("rstpend_data", {24'b0, tx_data_in}, 32'h0);
    rst = 1'b0;
    load(32'h8000_0010, 32'h0, "rstpend_cycle");
    load(32'h8000_0014, 32'h0, "rstpend_instr");
    tx_data_in_ready = 1'b1;
    step();
    step();
    check("rstpend_no_hs", hs_cnt - base, 32'd0);
    check("rstpend_still_idle", {31'b0, tx_data_in_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
